// File: rtl/twiddle_gen_if.sv
// twiddle_gen_if: request/stream bundle between an FFT stage controller and the twiddle sequencer
interface twiddle_gen_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2N      = 4
);
  logic                    start;
  logic [LOG2N-1:0]        stride;
  logic [LOG2N:0]          length;
  logic                    inverse;
  logic                    out_ready;
  logic                    out_valid;
  logic [2*DATA_WIDTH-1:0] out_data;
  logic [LOG2N-1:0]        out_index;
  logic                    out_last;
  logic                    busy;
  logic                    done;
  modport master (
    output start, stride, length, inverse, out_ready,
    input  out_valid, out_data, out_index, out_last, busy, done
  );
  modport slave (
    input  start, stride, length, inverse, out_ready,
    output out_valid, out_data, out_index, out_last, busy, done
  );
endinterface

// File: rtl/twiddle_gen.sv
// twiddle_gen: streams W_N^k for k = 0, s, 2s, ... mod N from a quarter-wave cosine table
module twiddle_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2N      = 4
) (
  input logic         clk,
  input logic         rst,
  twiddle_gen_if.slave bus
);
  localparam int N  = 1 << LOG2N;
  localparam int Q  = N / 4;
  localparam int DW = DATA_WIDTH;
  localparam int QW = $clog2(Q + 1);
  localparam logic [LOG2N:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  function automatic logic signed [DW-1:0] cos_q(input int i);
    real v;
    v = $cos(2.0 * 3.14159265358979323846 * i / N) * (2.0 ** (DW - 2));
    return v >= 0.0 ? DW'($rtoi(v + 0.5)) : DW'(-$rtoi(0.5 - v));
  endfunction
  logic signed [DW-1:0] tbl [Q+1];
  for (genvar g = 0; g <= Q; g++) begin : g_tbl
    assign tbl[g] = cos_q(g);
  end
  state_t               state, nxt;
  logic [LOG2N-1:0]     k, stride_r, issue_k, k1, k2;
  logic [LOG2N:0]       rem;
  logic [QW-1:0]        i1, j1;
  logic [1:0]           q;
  logic                 inv_r, adv, fin, issue, issue_last, issue_inv;
  logic                 v1, last1, inv1, v2, last2, inv2;
  logic signed [DW-1:0] c2, s2, re, im0, im;
  assign adv     = !bus.out_valid || bus.out_ready;
  assign fin     = bus.out_valid && bus.out_ready && bus.out_last;
  assign bus.busy = state != IDLE;
  assign issue_k = state == IDLE ? '0 : k;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt        = state;
    issue      = 1'b0;
    issue_last = 1'b0;
    issue_inv  = inv_r;
    case (state)
      IDLE: begin
        issue      = bus.start && bus.length != '0;
        issue_last = bus.length == ONE;
        issue_inv  = bus.inverse;
        if (issue) nxt = issue_last ? DRAIN : RUN;
      end
      RUN: begin
        issue      = adv;
        issue_last = rem == ONE;
        if (adv && issue_last) nxt = DRAIN;
      end
      DRAIN: if (fin) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // k=0 is issued on the start edge itself, so k/rem already point at the second beat
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      k        <= '0;
      stride_r <= '0;
      rem      <= '0;
      inv_r    <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= (state == IDLE && bus.start && bus.length == '0) || (state == DRAIN && fin);
      if (state == IDLE && issue) begin
        k        <= bus.stride;
        stride_r <= bus.stride;
        rem      <= bus.length - ONE;
        inv_r    <= bus.inverse;
      end else if (state == RUN && adv) begin
        k   <= k + stride_r;
        rem <= rem - ONE;
      end
    end
  assign i1  = QW'(k1 & LOG2N'(Q - 1));
  assign j1  = QW'(Q) - i1;
  assign q   = k2[LOG2N-1 -: 2];
  assign re  = q == 2'd0 ? c2 : q == 2'd1 ? -s2 : q == 2'd2 ? -c2 : s2;
  assign im0 = q == 2'd0 ? -s2 : q == 2'd1 ? -c2 : q == 2'd2 ? s2 : c2;
  assign im  = inv2 ? -im0 : im0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {v1, k1, last1, inv1}               <= '0;
      {v2, k2, last2, inv2}               <= '0;
      c2                                  <= '0;
      s2                                  <= '0;
      bus.out_valid                       <= 1'b0;
      bus.out_index                       <= '0;
      bus.out_last                        <= 1'b0;
      bus.out_data                        <= '0;
    end else if (adv) begin
      v1            <= issue;
      k1            <= issue_k;
      last1         <= issue && issue_last;
      inv1          <= issue_inv;
      v2            <= v1;
      k2            <= k1;
      last2         <= last1;
      inv2          <= inv1;
      c2            <= tbl[i1];
      s2            <= tbl[j1];
      bus.out_valid <= v2;
      bus.out_index <= k2;
      bus.out_last  <= last2;
      bus.out_data  <= {re, im};
    end
endmodule

// File: tb/tb_twiddle_gen.sv
// tb_twiddle_gen: directed scenarios for twiddle_gen at DATA_WIDTH=16, N=16
module tb_twiddle_gen;
  localparam logic [31:0] WTAB [16] = '{
    32'h4000_0000, 32'h3B21_E782, 32'h2D41_D2BF, 32'h187E_C4DF,
    32'h0000_C000, 32'hE782_C4DF, 32'hD2BF_D2BF, 32'hC4DF_E782,
    32'hC000_0000, 32'hC4DF_187E, 32'hD2BF_2D41, 32'hE782_3B21,
    32'h0000_4000, 32'h187E_3B21, 32'h2D41_2D41, 32'h3B21_187E};
  localparam logic [31:0] INV4 [4] = '{32'h4000_0000, 32'h0000_4000, 32'hC000_0000, 32'h0000_C000};
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  twiddle_gen_if #(.DATA_WIDTH(16), .LOG2N(4)) bus();
  twiddle_gen #(.DATA_WIDTH(16), .LOG2N(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [31:0] d_q [64];
  logic [3:0]  i_q [64];
  logic        l_q [64];
  logic [31:0] st_d [3];
  logic [3:0]  st_i [3];
  logic        st_l [3];
  int n, ndone, first, done_cyc, nst;
  logic busy0;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int s, input int l, input logic inv, input int stall_k, input int poke);
    bus.start = 1'b1; bus.stride = 4'(s); bus.length = 5'(l); bus.inverse = inv; bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0; ndone = 0; first = -1; done_cyc = -1; nst = 0; busy0 = bus.busy;
    for (int c = 0; c < 120; c++) begin
      if (bus.out_valid && first < 0) first = c;
      bus.out_ready = 1'b1;
      bus.start = c == poke;
      if (c == poke) begin bus.stride = 4'd7; bus.length = 5'd3; bus.inverse = ~inv; end
      if (bus.out_valid && int'(bus.out_index) == stall_k && nst < 3) begin
        bus.out_ready = 1'b0;
        st_d[nst] = bus.out_data; st_i[nst] = bus.out_index; st_l[nst] = bus.out_last;
        nst++;
      end else if (bus.out_valid && n < 64) begin
        d_q[n] = bus.out_data; i_q[n] = bus.out_index; l_q[n] = bus.out_last;
        n++;
      end
      if (bus.done) begin ndone++; done_cyc = c; end
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
      tick();
    end
    bus.start = 1'b0;
  endtask
  task automatic test_reset();
    n_cmp++;
    if ({bus.out_valid, bus.out_data, bus.out_index, bus.out_last, bus.busy, bus.done} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got valid=%b data=%h idx=%0d last=%b busy=%b done=%b, want all 0",
        bus.out_valid, bus.out_data, bus.out_index, bus.out_last, bus.busy, bus.done);
    end
  endtask
  task automatic test_full_wave();
    run(1, 16, 1'b0, -1, -1);
    n_cmp++; if (n !== 16) begin n_err++; $display("FAIL full_count: got %0d want 16", n); end
    n_cmp++; if (first !== 2) begin n_err++; $display("FAIL full_latency: got %0d want 2", first); end
    n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL full_busy: got %b want 1", busy0); end
    n_cmp++; if (done_cyc !== 18 || ndone !== 1) begin n_err++; $display("FAIL full_done: got cyc %0d count %0d want 18/1", done_cyc, ndone); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (i_q[i] !== 4'(i) || d_q[i] !== WTAB[i] || l_q[i] !== (i == 15)) begin
        n_err++; $display("FAIL full_beat%0d: got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
          i, i_q[i], d_q[i], l_q[i], i, WTAB[i], i == 15);
      end
    end
  endtask
  task automatic test_stride3();
    int exp_k [8] = '{0, 3, 6, 9, 12, 15, 2, 5};
    run(3, 8, 1'b0, -1, -1);
    n_cmp++; if (n !== 8 || done_cyc !== 10) begin n_err++; $display("FAIL s3_count: got n=%0d done_cyc=%0d want 8/10", n, done_cyc); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (i_q[i] !== 4'(exp_k[i]) || d_q[i] !== WTAB[exp_k[i]] || l_q[i] !== (i == 7)) begin
        n_err++; $display("FAIL s3_beat%0d: got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
          i, i_q[i], d_q[i], l_q[i], exp_k[i], WTAB[exp_k[i]], i == 7);
      end
    end
  endtask
  task automatic test_inverse(input int stall_k);
    run(4, 4, 1'b1, stall_k, -1);
    n_cmp++; if (n !== 4 || ndone !== 1) begin n_err++; $display("FAIL inv_count: got n=%0d done=%0d want 4/1", n, ndone); end
    n_cmp++; if (done_cyc !== (stall_k < 0 ? 6 : 9)) begin n_err++; $display("FAIL inv_done_cyc: got %0d want %0d", done_cyc, stall_k < 0 ? 6 : 9); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i_q[i] !== 4'(4 * i) || d_q[i] !== INV4[i] || l_q[i] !== (i == 3)) begin
        n_err++; $display("FAIL inv_beat%0d: got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
          i, i_q[i], d_q[i], l_q[i], 4 * i, INV4[i], i == 3);
      end
    end
  endtask
  task automatic test_stall();
    test_inverse(4);
    n_cmp++; if (nst !== 3) begin n_err++; $display("FAIL stall_cycles: got %0d want 3", nst); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (st_d[i] !== 32'h0000_4000 || st_i[i] !== 4'd4 || st_l[i] !== 1'b0) begin
        n_err++; $display("FAIL stall_hold%0d: got data=%h idx=%0d last=%b want 00004000/4/0", i, st_d[i], st_i[i], st_l[i]);
      end
    end
  endtask
  task automatic test_zero_len();
    logic seen;
    bus.start = 1'b1; bus.stride = 4'd1; bus.length = 5'd0; bus.inverse = 1'b0;
    tick();
    bus.start = 1'b0;
    n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL zlen_done: got %b want 1", bus.done); end
    n_cmp++; if ({bus.out_valid, bus.busy} !== 2'b00) begin n_err++; $display("FAIL zlen_idle: got valid/busy %b%b want 00", bus.out_valid, bus.busy); end
    tick();
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL zlen_pulse: got %b want 0", bus.done); end
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin seen |= bus.out_valid; tick(); end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL zlen_novalid: got %b want 0", seen); end
  endtask
  task automatic test_start_busy();
    run(1, 4, 1'b0, -1, 1);
    n_cmp++; if (n !== 4 || ndone !== 1 || done_cyc !== 6) begin
      n_err++; $display("FAIL busy_start: got n=%0d done=%0d cyc=%0d want 4/1/6", n, ndone, done_cyc);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i_q[i] !== 4'(i) || d_q[i] !== WTAB[i]) begin
        n_err++; $display("FAIL busy_beat%0d: got idx=%0d data=%h want %0d/%h", i, i_q[i], d_q[i], i, WTAB[i]);
      end
    end
  endtask
  task automatic test_reset_mid();
    logic seen;
    bus.start = 1'b1; bus.stride = 4'd1; bus.length = 5'd16; bus.inverse = 1'b0; bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 20 && !(bus.out_valid && bus.out_index == 4'd5); c++) tick();
    n_cmp++; if (!(bus.out_valid && bus.out_index == 4'd5)) begin n_err++; $display("FAIL rmid_reach: got valid=%b idx=%0d want 1/5", bus.out_valid, bus.out_index); end
    #2 rst = 1'b1;
    #1;
    test_reset();
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin seen |= bus.done | bus.out_valid | bus.busy; tick(); end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rmid_quiet: got activity=%b want 0", seen); end
    run(1, 16, 1'b0, -1, -1);
    n_cmp++; if (n !== 16 || i_q[0] !== 4'd0 || d_q[0] !== WTAB[0] || ndone !== 1) begin
      n_err++; $display("FAIL rmid_restart: got n=%0d idx0=%0d data0=%h done=%0d want 16/0/40000000/1", n, i_q[0], d_q[0], ndone);
    end
  endtask
  initial begin
    bus.start = 1'b0; bus.stride = '0; bus.length = '0; bus.inverse = 1'b0; bus.out_ready = 1'b1;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_full_wave();
    test_stride3();
    test_inverse(-1);
    test_stall();
    test_zero_len();
    test_start_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
